ctrl_stream_switch: RTL and testbench
=====================================

# ctrl_stream_switch

Packet-aware, buffered successor to the single-beat control-stream crossbar in the multi-channel Fano decoder wrapper. One input stream with valid/ready handshake is routed per packet to one of N_CHS decoder control ports, or broadcast to all. Each output has its own FIFO, so a stalled channel does not corrupt framing. Sits between the `i_ctrl_*` stream and the per-channel `fano_decoder` control inputs, in the `i_ctrl_clk` domain.

## Interface
- DATA_WIDTH, 24, payload width per beat
- N_CHS, 4, output channels, 1..16
- FIFO_DEPTH, 8, words per channel FIFO; power of two, >= 2
- SEL_W (localparam), max(1, log2(N_CHS)), select width
- clk  in  1  stream clock; single clock domain
- reset_n  in  1  asynchronous, active-low reset
- i_valid  in  1  input beat valid
- i_data  in  DATA_WIDTH  input payload
- i_last  in  1  last beat of packet
- o_ready  out  1  input beat accepted when i_valid & o_ready
- i_dev_sel  in  SEL_W  target channel; sampled on first beat only
- i_bcast  in  1  broadcast packet to all channels; sampled on first beat only
- i_err_clr  in  1  clears o_sel_err
- o_valid  out  N_CHS  per-channel beat valid
- o_data  out  DATA_WIDTH*N_CHS  channel k at [DATA_WIDTH*(k+1)-1 -: DATA_WIDTH]
- o_last  out  N_CHS  per-channel last flag
- i_ready  in  N_CHS  per-channel downstream ready
- o_busy  out  1  high while a packet is in progress (state != IDLE)
- o_sel_err  out  1  sticky: packet addressed to channel >= N_CHS

## Operation
- FSM states: IDLE, PKT, DROP.
- IDLE, first beat accepted: latch sel and bcast. If sel >= N_CHS and !bcast, set o_sel_err and discard the beat. If i_last is high, stay in IDLE; this is a single-beat packet. Otherwise go to PKT (valid target) or DROP (invalid target).
- PKT: route to the latched target. Return to IDLE on the accepted beat that has i_last set.
- DROP: o_ready=1 and beats are discarded. Return to IDLE on the accepted last beat.
- o_ready:
  - unicast: !full[sel]
  - broadcast: AND of !full over all channels
  - DROP, or IDLE with an invalid select: 1
  - In IDLE, sel and bcast are taken live from the inputs.
- Write rule: an accepted beat pushes {i_last, i_data} into the target FIFO, or into every FIFO on broadcast.
- Full FIFO: no write. o_ready depends on the full flag only, so a simultaneous read does not free the slot in the same cycle.
- Read side, per channel: FWFT. o_valid[k] = !empty[k]. Pop on o_valid[k] & i_ready[k].
- Simultaneous push and pop on a non-full, non-empty FIFO: count unchanged, both take effect.
- Pointers are log2(FIFO_DEPTH)+1 bits; the MSB distinguishes full from empty; pointers wrap modulo 2*FIFO_DEPTH.
- o_sel_err: set-dominant over i_err_clr in the same cycle.
- Reset mid-packet: FSM → IDLE, all FIFOs flushed, latched select cleared. The remainder of the interrupted packet is then treated as a new packet.
- Reset values: o_ready=0 while reset_n is low, and 1 in IDLE after reset. o_valid=0, o_last=0, o_data=0, o_busy=0, o_sel_err=0.

## Timing
- Latency: a beat accepted in cycle t appears on o_valid/o_data in cycle t+1 (registered FIFO write, FWFT read).
- Throughput: one beat per clock when the target FIFO is not full.
- o_ready is combinational from the FSM state, the latched or live select, and the registered full flags. There is no path from i_ready to o_ready.
- Full deasserts the cycle after a pop. The stalled input beat is accepted in cycle pop+1.
- o_busy rises the cycle after the first beat of a multi-beat packet. It falls the cycle after the last beat.

## Structure
- Shared package: the `ctrl_sw_state_t` enum (IDLE, PKT, DROP) goes in `math_pkg`, alongside the existing `log2` used for SEL_W and pointer widths.
- Sub-module `sync_fifo_fwft` (WIDTH, DEPTH; push, pop, data, full, empty). Instantiate it N_CHS times in a generate loop.
- Top: FSM, select latch, ready/write fan-out, error flag.

## Test plan
- Reset, then a 3-beat unicast packet to sel=2, data 0x000001..0x000003 → o_valid[2] from cycle t+1, three beats, o_last on the third; other channels idle.
- Broadcast 2-beat packet with i_ready[1]=0 and FIFO_DEPTH=8 → every channel receives both beats; channel 1 holds them until ready rises.
- Fill channel 0 with 8 beats while i_ready[0]=0 → o_ready=0 on beat 9. Raise i_ready[0] for 1 cycle → beat 9 accepted the cycle after, with no data loss.
- N_CHS=3, sel=3, 4-beat packet → all beats accepted and dropped, o_sel_err=1, no o_valid. i_err_clr → o_sel_err=0.
- Change i_dev_sel from 0 to 1 mid-packet → all beats of the packet go to channel 0. The next packet goes to channel 1.
- Assert reset_n=0 during beat 2 of a 4-beat packet → o_valid all 0 and o_busy=0 immediately. After release, o_ready=1 in IDLE.

Source files
------------

// File: rtl/math_pkg.sv
// math_pkg: shared switch FSM state type and ceil-log2 helper
package math_pkg;
  typedef enum logic [1:0] {IDLE, PKT, DROP} ctrl_sw_state_t;
  function automatic int log2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) ;
    return r;
  endfunction
endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: first-word-fall-through FIFO with wrap-bit pointers
module sync_fifo_fwft import math_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = log2(DEPTH);
  localparam logic [AW:0] ONE = 1;
  logic [AW:0] wr_q, rd_q, wr_d, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic do_push, do_pop;
  // Flags from pointers; head word is zeroed when empty so outputs stay clean
  always_comb begin
    empty_o = wr_q == rd_q;
    full_o = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    do_push = push_i & !full_o;
    do_pop = pop_i & !empty_o;
    wr_d = do_push ? wr_q + ONE : wr_q;
    rd_d = do_pop ? rd_q + ONE : rd_q;
    rdata_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];
  end
  // Pointer registers; reset flushes the FIFO
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  // Storage array, written at the tail
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end
endmodule

// File: rtl/ctrl_stream_switch.sv
// ctrl_stream_switch: packet-aware stream router with per-channel FIFOs and broadcast
module ctrl_stream_switch import math_pkg::*; #(
  parameter int DATA_WIDTH = 24,
  parameter int N_CHS = 4,
  parameter int FIFO_DEPTH = 8,
  localparam int SEL_W = (log2(N_CHS) > 1) ? log2(N_CHS) : 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        i_valid,
  input  logic [DATA_WIDTH-1:0]       i_data,
  input  logic                        i_last,
  output logic                        o_ready,
  input  logic [SEL_W-1:0]            i_dev_sel,
  input  logic                        i_bcast,
  input  logic                        i_err_clr,
  output logic [N_CHS-1:0]            o_valid,
  output logic [DATA_WIDTH*N_CHS-1:0] o_data,
  output logic [N_CHS-1:0]            o_last,
  input  logic [N_CHS-1:0]            i_ready,
  output logic                        o_busy,
  output logic                        o_sel_err
);
  ctrl_sw_state_t state_q;
  logic [SEL_W-1:0] sel_q, sel;
  logic bcast_q, bcast, err_q, err_d;
  logic idle, in_range, drop, accept;
  logic [N_CHS-1:0] full, empty, tgt, push;
  // Live select in IDLE, latched select mid-packet; ready depends only on registered full flags
  always_comb begin
    idle = state_q == IDLE;
    sel = idle ? i_dev_sel : sel_q;
    bcast = idle ? i_bcast : bcast_q;
    in_range = bcast | (32'(sel) < N_CHS);
    drop = (state_q == DROP) | (idle & !in_range);
    tgt = bcast ? '1 : N_CHS'(1) << sel;
    o_ready = reset_n & (drop | ~|(full & tgt));
    accept = i_valid & o_ready;
    push = (accept & !drop) ? tgt : '0;
    err_d = (accept & idle & !in_range) | (err_q & !i_err_clr);
  end
  // Packet FSM, select latch and sticky select-error flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sel_q <= '0;
      bcast_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
      if (accept)
        case (state_q)
          IDLE: begin
            sel_q <= i_dev_sel;
            bcast_q <= i_bcast;
            if (!i_last) state_q <= in_range ? PKT : DROP;
          end
          default: if (i_last) state_q <= IDLE;
        endcase
    end
  end
  assign o_busy = state_q != IDLE;
  assign o_sel_err = err_q;
  for (genvar k = 0; k < N_CHS; k++) begin : g_ch
    logic [DATA_WIDTH:0] rd;
    sync_fifo_fwft #(.WIDTH(DATA_WIDTH + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk),
      .reset_n(reset_n),
      .push_i(push[k]),
      .pop_i(i_ready[k]),
      .wdata_i({i_last, i_data}),
      .rdata_o(rd),
      .full_o(full[k]),
      .empty_o(empty[k])
    );
    assign o_valid[k] = !empty[k];
    assign o_last[k] = rd[DATA_WIDTH];
    assign o_data[DATA_WIDTH*k +: DATA_WIDTH] = rd[DATA_WIDTH-1:0];
  end
endmodule

// File: tb/tb_ctrl_stream_switch.sv
// tb_ctrl_stream_switch: directed checks of routing, broadcast, backpressure, drop and reset
module tb_ctrl_stream_switch;
  localparam int DW = 24;
  localparam int NC = 3;
  logic clk = 1'b0;
  logic reset_n, i_valid, i_last, i_bcast, i_err_clr, o_ready, o_busy, o_sel_err;
  logic [DW-1:0] i_data;
  logic [1:0] i_dev_sel;
  logic [NC-1:0] o_valid, o_last, i_ready;
  logic [DW*NC-1:0] o_data;
  int n_chk = 0;
  int n_fail = 0;

  ctrl_stream_switch #(.DATA_WIDTH(DW), .N_CHS(NC), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .i_valid(i_valid), .i_data(i_data), .i_last(i_last),
    .o_ready(o_ready), .i_dev_sel(i_dev_sel), .i_bcast(i_bcast), .i_err_clr(i_err_clr),
    .o_valid(o_valid), .o_data(o_data), .o_last(o_last), .i_ready(i_ready),
    .o_busy(o_busy), .o_sel_err(o_sel_err)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] ch(input int k);
    return o_data[DW*k +: DW];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [1:0] sel, input logic bc, input logic [DW-1:0] d, input logic l);
    i_valid = 1'b1;
    i_dev_sel = sel;
    i_bcast = bc;
    i_data = d;
    i_last = l;
  endtask

  initial begin
    reset_n = 1'b0;
    i_valid = 1'b0;
    i_data = '0;
    i_last = 1'b0;
    i_dev_sel = '0;
    i_bcast = 1'b0;
    i_err_clr = 1'b0;
    i_ready = '0;
    #2;
    chk("rst_ready", 64'(o_ready), 64'd0);
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_err", 64'(o_sel_err), 64'd0);
    chk("rst_last", 64'(o_last), 64'd0);
    chk("rst_data", 64'(o_data), 64'd0);
    tick;
    tick;
    reset_n = 1'b1;
    #1;
    chk("idle_ready", 64'(o_ready), 64'd1);

    beat(2'd2, 1'b0, 24'h000001, 1'b0);
    tick;
    chk("uc_valid_t1", 64'(o_valid), 64'b100);
    chk("uc_data_t1", 64'(ch(2)), 64'h1);
    chk("uc_busy", 64'(o_busy), 64'd1);
    beat(2'd2, 1'b0, 24'h000002, 1'b0);
    tick;
    beat(2'd2, 1'b0, 24'h000003, 1'b1);
    tick;
    i_valid = 1'b0;
    chk("uc_busy_end", 64'(o_busy), 64'd0);
    chk("uc_valid_only2", 64'(o_valid), 64'b100);
    i_ready = 3'b100;
    #1;
    chk("uc_b1_last", 64'(o_last[2]), 64'd0);
    tick;
    chk("uc_b2", 64'(ch(2)), 64'h2);
    tick;
    chk("uc_b3", 64'(ch(2)), 64'h3);
    chk("uc_b3_last", 64'(o_last), 64'b100);
    tick;
    chk("uc_drained", 64'(o_valid), 64'd0);

    i_ready = 3'b101;
    beat(2'd0, 1'b1, 24'h0000AA, 1'b0);
    #1;
    chk("bc_ready", 64'(o_ready), 64'd1);
    tick;
    beat(2'd0, 1'b1, 24'h0000BB, 1'b1);
    tick;
    i_valid = 1'b0;
    i_bcast = 1'b0;
    chk("bc_valid_all", 64'(o_valid), 64'b111);
    chk("bc_ch0", 64'(ch(0)), 64'hBB);
    chk("bc_ch1_held", 64'(ch(1)), 64'hAA);
    chk("bc_ch2", 64'(ch(2)), 64'hBB);
    tick;
    chk("bc_ch1_only", 64'(o_valid), 64'b010);
    chk("bc_ch1_still", 64'(ch(1)), 64'hAA);
    i_ready = 3'b010;
    tick;
    chk("bc_ch1_b2", 64'(ch(1)), 64'hBB);
    chk("bc_ch1_last", 64'(o_last), 64'b010);
    tick;
    chk("bc_drained", 64'(o_valid), 64'd0);

    i_ready = '0;
    for (int i = 0; i < 8; i++) begin
      beat(2'd0, 1'b0, 24'h000100 + 24'(i), 1'b0);
      tick;
    end
    beat(2'd0, 1'b0, 24'h000108, 1'b1);
    #1;
    chk("full_ready", 64'(o_ready), 64'd0);
    chk("full_busy", 64'(o_busy), 64'd1);
    i_ready = 3'b001;
    tick;
    i_ready = '0;
    chk("full_ready_after_pop", 64'(o_ready), 64'd1);
    tick;
    i_valid = 1'b0;
    #1;
    chk("full_again", 64'(o_ready), 64'd0);
    chk("full_busy_end", 64'(o_busy), 64'd0);
    i_ready = 3'b001;
    for (int i = 0; i < 8; i++) begin
      chk("full_drain_data", 64'(ch(0)), 64'h101 + 64'(i));
      chk("full_drain_last", 64'(o_last[0]), (i == 7) ? 64'd1 : 64'd0);
      tick;
    end
    chk("full_drained", 64'(o_valid), 64'd0);
    i_ready = '0;

    beat(2'd3, 1'b0, 24'h000300, 1'b0);
    #1;
    chk("bad_sel_ready", 64'(o_ready), 64'd1);
    tick;
    chk("bad_sel_err", 64'(o_sel_err), 64'd1);
    chk("bad_sel_busy", 64'(o_busy), 64'd1);
    for (int i = 1; i < 4; i++) begin
      beat(2'd0, 1'b0, 24'h000300 + 24'(i), i == 3);
      tick;
    end
    i_valid = 1'b0;
    chk("drop_no_valid", 64'(o_valid), 64'd0);
    chk("drop_busy_end", 64'(o_busy), 64'd0);
    chk("drop_err_sticky", 64'(o_sel_err), 64'd1);
    i_err_clr = 1'b1;
    tick;
    i_err_clr = 1'b0;
    chk("err_cleared", 64'(o_sel_err), 64'd0);

    beat(2'd0, 1'b0, 24'h000201, 1'b0);
    tick;
    beat(2'd1, 1'b0, 24'h000202, 1'b0);
    tick;
    beat(2'd1, 1'b0, 24'h000203, 1'b1);
    tick;
    chk("latch_ch0_only", 64'(o_valid), 64'b001);
    beat(2'd1, 1'b0, 24'h000055, 1'b1);
    tick;
    i_valid = 1'b0;
    chk("next_pkt_ch1", 64'(o_valid), 64'b011);
    chk("next_pkt_data", 64'(ch(1)), 64'h55);
    chk("next_pkt_busy", 64'(o_busy), 64'd0);
    chk("latch_head", 64'(ch(0)), 64'h201);
    i_ready = 3'b011;
    tick;
    chk("latch_b2_ch0", 64'(ch(0)), 64'h202);
    tick;
    tick;
    chk("latch_drained", 64'(o_valid), 64'd0);
    i_ready = '0;

    beat(2'd2, 1'b0, 24'h000401, 1'b0);
    tick;
    beat(2'd2, 1'b0, 24'h000402, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(o_valid), 64'd0);
    chk("mid_rst_busy", 64'(o_busy), 64'd0);
    chk("mid_rst_ready", 64'(o_ready), 64'd0);
    tick;
    reset_n = 1'b1;
    i_valid = 1'b0;
    #1;
    chk("post_rst_ready", 64'(o_ready), 64'd1);
    chk("post_rst_busy", 64'(o_busy), 64'd0);
    chk("post_rst_valid", 64'(o_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
